// File: rtl/vq_encoder.sv
// vq_encoder: vector-quantisation encoder.
// Loads a 64-entry RGB codebook, then maps each source pixel to the index of
// its nearest codeword (Manhattan distance, ties to lowest index) and writes
// one tag word per pixel into the tag RAM.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           run request (sampled in IDLE and DONE only)
//   RAM1_Q/A/OE     codebook RAM read port
//   RAM0_Q/A/OE     source pixel RAM read port
//   RAM2_D/A/WE     tag RAM write port
//   busy, done      run status
module vq_encoder #(
    parameter int unsigned N_PIXEL = 262144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] RAM1_Q,
    output logic [19:0] RAM1_A,
    output logic        RAM1_OE,
    input  logic [23:0] RAM0_Q,
    output logic [19:0] RAM0_A,
    output logic        RAM0_OE,
    output logic [23:0] RAM2_D,
    output logic [19:0] RAM2_A,
    output logic        RAM2_WE,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW    = 20;
    localparam int unsigned DW    = 24;
    localparam int unsigned CB_N  = 64;
    localparam int unsigned IDXW  = 6;
    localparam int unsigned DISTW = 10;
    localparam int unsigned CNTW  = 7;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_CB = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_SEARCH  = 3'd4;
    localparam logic [2:0] S_WRITE   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [AW-1:0]   LAST_P   = AW'(N_PIXEL - 1);
    localparam logic [CNTW-1:0] LOAD_END = CNTW'(CB_N);
    localparam logic [CNTW-1:0] SRCH_END = CNTW'(CB_N - 1);

    logic [2:0]       state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]    p_q, p_d;
    logic [DISTW-1:0] best_d_q, best_d_d;
    logic [IDXW-1:0]  best_idx_q, best_idx_d;

    logic [DW-1:0]    cb_q [CB_N];
    logic [DW-1:0]    pix_q;

    logic [AW-1:0]    ram1_a_q, ram1_a_d;
    logic             ram1_oe_q, ram1_oe_d;
    logic [AW-1:0]    ram0_a_q, ram0_a_d;
    logic             ram0_oe_q, ram0_oe_d;
    logic [DW-1:0]    ram2_d_q, ram2_d_d;
    logic [AW-1:0]    ram2_a_q, ram2_a_d;
    logic             ram2_we_q, ram2_we_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DW-1:0]    cb_k_c;
    logic [DISTW-1:0] dist_c;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Manhattan distance between the latched pixel and the codeword under test
    always_comb begin
        cb_k_c = cb_q[cnt_q[IDXW-1:0]];
        dist_c = DISTW'(abs_diff(pix_q[23:16], cb_k_c[23:16]))
               + DISTW'(abs_diff(pix_q[15:8],  cb_k_c[15:8]))
               + DISTW'(abs_diff(pix_q[7:0],   cb_k_c[7:0]));
    end

    // Next-state logic; outputs are derived from the next state so they register in step
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        best_d_d   = best_d_q;
        best_idx_d = best_idx_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD_CB;
                    cnt_d   = '0;
                    p_d     = '0;
                end
            end
            S_LOAD_CB: begin
                if (cnt_q == LOAD_END) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                state_d = S_SEARCH;
                cnt_d   = '0;
            end
            S_SEARCH: begin
                // first codeword loads unconditionally; strict < keeps the lowest index on ties
                if ((cnt_q == '0) || (dist_c < best_d_q)) begin
                    best_d_d   = dist_c;
                    best_idx_d = cnt_q[IDXW-1:0];
                end
                if (cnt_q == SRCH_END) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_WRITE: begin
                p_d     = p_q + AW'(1);
                state_d = (p_q == LAST_P) ? S_DONE : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        ram1_oe_d = (state_d == S_LOAD_CB) && (cnt_d < LOAD_END);
        ram1_a_d  = ram1_oe_d ? AW'(cnt_d) : '0;
        ram0_oe_d = (state_d == S_FETCH);
        ram0_a_d  = ram0_oe_d ? p_d : '0;
        ram2_we_d = (state_d == S_WRITE);
        ram2_a_d  = ram2_we_d ? p_d : '0;
        ram2_d_d  = ram2_we_d ? DW'(best_idx_d) : '0;
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            p_q        <= '0;
            best_d_q   <= '0;
            best_idx_q <= '0;
            ram1_a_q   <= '0;
            ram1_oe_q  <= 1'b0;
            ram0_a_q   <= '0;
            ram0_oe_q  <= 1'b0;
            ram2_d_q   <= '0;
            ram2_a_q   <= '0;
            ram2_we_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            best_d_q   <= best_d_d;
            best_idx_q <= best_idx_d;
            ram1_a_q   <= ram1_a_d;
            ram1_oe_q  <= ram1_oe_d;
            ram0_a_q   <= ram0_a_d;
            ram0_oe_q  <= ram0_oe_d;
            ram2_d_q   <= ram2_d_d;
            ram2_a_q   <= ram2_a_d;
            ram2_we_q  <= ram2_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Codebook and pixel storage: unreset, always reloaded before use.
    // Read data for address k arrives during load cycle k+1.
    always_ff @(posedge clk) begin
        if ((state_q == S_LOAD_CB) && (cnt_q != '0)) begin
            cb_q[IDXW'(cnt_q - CNTW'(1))] <= RAM1_Q;
        end
        if (state_q == S_LATCH) begin
            pix_q <= RAM0_Q;
        end
    end

    assign RAM1_A  = ram1_a_q;
    assign RAM1_OE = ram1_oe_q;
    assign RAM0_A  = ram0_a_q;
    assign RAM0_OE = ram0_oe_q;
    assign RAM2_D  = ram2_d_q;
    assign RAM2_A  = ram2_a_q;
    assign RAM2_WE = ram2_we_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_vq_encoder.sv
// tb_vq_encoder: bench for vq_encoder with N_PIXEL=4.
// Models the three synchronous RAMs, computes expected tags by brute-force
// nearest-codeword search, and checks latency, strobe counts and reset behaviour.
module tb_vq_encoder;

    localparam int unsigned NP = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic        clr   = 1'b0;
    logic [23:0] RAM1_Q = '0;
    logic [23:0] RAM0_Q = '0;
    logic [19:0] RAM1_A, RAM0_A, RAM2_A;
    logic        RAM1_OE, RAM0_OE, RAM2_WE, busy, done;
    logic [23:0] RAM2_D;

    logic [23:0] cbmem  [64];
    logic [23:0] pixmem [NP];
    logic [23:0] tagmem [NP];

    int vectors     = 0;
    int miscompares = 0;
    int we_cnt      = 0;
    int oe1_cnt     = 0;
    int viol        = 0;

    always #5 clk = ~clk;

    vq_encoder #(.N_PIXEL(NP)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .RAM1_Q  (RAM1_Q),
        .RAM1_A  (RAM1_A),
        .RAM1_OE (RAM1_OE),
        .RAM0_Q  (RAM0_Q),
        .RAM0_A  (RAM0_A),
        .RAM0_OE (RAM0_OE),
        .RAM2_D  (RAM2_D),
        .RAM2_A  (RAM2_A),
        .RAM2_WE (RAM2_WE),
        .busy    (busy),
        .done    (done)
    );

    // Synchronous RAM models and strobe counters
    always @(posedge clk) begin
        if (RAM1_OE) RAM1_Q <= cbmem[RAM1_A[5:0]];
        if (RAM0_OE) RAM0_Q <= pixmem[RAM0_A[1:0]];
        if (clr) begin
            we_cnt  <= 0;
            oe1_cnt <= 0;
            for (int i = 0; i < NP; i++) tagmem[i] <= 24'hFFFFFF;
        end else begin
            if (RAM2_WE) begin
                tagmem[RAM2_A[1:0]] <= RAM2_D;
                we_cnt <= we_cnt + 1;
            end
            if (RAM1_OE) oe1_cnt <= oe1_cnt + 1;
        end
    end

    // Idle addresses must be 0, addresses in range, busy/done exclusive
    always @(negedge clk) begin
        if ((!RAM1_OE && RAM1_A != 0) || (!RAM0_OE && RAM0_A != 0) ||
            (!RAM2_WE && (RAM2_A != 0 || RAM2_D != 0)) ||
            (RAM1_OE && RAM1_A > 63) || (RAM0_OE && RAM0_A >= NP) ||
            (RAM2_WE && (RAM2_A >= NP || RAM2_D[23:6] != 0)) ||
            (busy && done))
            viol <= viol + 1;
    end

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference: exhaustive nearest codeword, lowest index wins ties
    function automatic logic [5:0] nearest(input logic [23:0] px);
        int best = 1 << 30;
        int bi   = 0;
        for (int k = 0; k < 64; k++) begin
            int d;
            d = absdiff(int'(px[23:16]), int'(cbmem[k][23:16]))
              + absdiff(int'(px[15:8]),  int'(cbmem[k][15:8]))
              + absdiff(int'(px[7:0]),   int'(cbmem[k][7:0]));
            if (d < best) begin
                best = d;
                bi   = k;
            end
        end
        return 6'(bi);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_cb(input logic [23:0] v);
        for (int k = 0; k < 64; k++) cbmem[k] = v;
    endtask

    task automatic run_check(input string name, input bit mid_start);
        int n;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "_busy_rise"}, 32'(busy), 1);
        chk({name, "_done_clear"}, 32'(done), 0);
        n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
            if (mid_start && n == 150) start = 1'b1;
            if (mid_start && n == 151) start = 1'b0;
        end
        chk({name, "_cycles"}, 32'(n), 333);
        chk({name, "_busy_fall"}, 32'(busy), 0);
        chk({name, "_we_pulses"}, 32'(we_cnt), 4);
        chk({name, "_oe1_cycles"}, 32'(oe1_cnt), 64);
        for (int i = 0; i < NP; i++)
            chk({name, "_tag", $sformatf("%0d", i)}, 32'(tagmem[i]), 32'(nearest(pixmem[i])));
        repeat (5) tick();
        chk({name, "_done_hold"}, 32'(done), 1);
    endtask

    initial begin
        // Reset held while start toggles
        for (int i = 0; i < 6; i++) begin
            start = ~start;
            tick();
        end
        chk("rst_ctrl", {27'd0, RAM1_OE, RAM0_OE, RAM2_WE, busy, done}, 0);
        chk("rst_addr", 32'(RAM1_A | RAM0_A | RAM2_A), 0);
        chk("rst_data", 32'(RAM2_D), 0);
        start = 1'b0;
        rst   = 1'b1;
        repeat (20) tick();
        chk("idle_stay", {29'd0, busy, done, RAM1_OE}, 0);

        // Exact match, codebook {k,k,k}
        for (int k = 0; k < 64; k++) cbmem[k] = {8'(k), 8'(k), 8'(k)};
        pixmem[0] = 24'h252525; pixmem[1] = 24'h000000;
        pixmem[2] = 24'h3F3F3F; pixmem[3] = 24'h101010;
        run_check("exact", 1'b0);
        chk("exact_t0", 32'(tagmem[0]), 37);
        chk("exact_t1", 32'(tagmem[1]), 0);
        chk("exact_t2", 32'(tagmem[2]), 63);

        // Tie resolves to lowest index
        fill_cb(24'h000000);
        cbmem[5] = 24'h808080; cbmem[20] = 24'h808080;
        for (int i = 0; i < NP; i++) pixmem[i] = 24'h808080;
        run_check("tie", 1'b0);
        chk("tie_t0", 32'(tagmem[0]), 5);

        // Nearest wins over a close neighbour
        fill_cb(24'h000000);
        cbmem[9] = 24'h7F8080; cbmem[3] = 24'h808080;
        for (int i = 0; i < NP; i++) pixmem[i] = 24'h7F8081;
        run_check("near", 1'b0);
        chk("near_t0", 32'(tagmem[0]), 9);

        // Extremes, with a start pulse mid-run
        fill_cb(24'h000000);
        for (int i = 0; i < NP; i++) pixmem[i] = 24'hFFFFFF;
        run_check("ext_max", 1'b1);
        chk("ext_max_t3", 32'(tagmem[3]), 0);
        cbmem[63] = 24'hFEFFFF;
        run_check("ext_last", 1'b0);
        chk("ext_last_t0", 32'(tagmem[0]), 63);

        // Random codebooks, full range and narrow range to force ties
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 64; k++)
                cbmem[k] = (r == 2) ? {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                                       8'($urandom_range(0, 3))} : 24'($urandom);
            for (int i = 0; i < NP; i++)
                pixmem[i] = (r == 2) ? {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                                        8'($urandom_range(0, 3))} : 24'($urandom);
            run_check($sformatf("rand%0d", r), 1'b0);
        end

        // Reset during SEARCH of pixel 2
        for (int k = 0; k < 64; k++) cbmem[k] = 24'($urandom);
        for (int i = 0; i < NP; i++) pixmem[i] = 24'($urandom);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (221) tick();
        chk("abort_pre_we", 32'(we_cnt), 2);
        rst = 1'b0;
        #1;
        chk("abort_ctrl", {27'd0, RAM1_OE, RAM0_OE, RAM2_WE, busy, done}, 0);
        chk("abort_addr", 32'(RAM1_A | RAM0_A | RAM2_A), 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (150) tick();
        chk("abort_no_we", 32'(we_cnt), 2);
        chk("abort_idle", {30'd0, busy, done}, 0);
        run_check("rerun", 1'b0);

        chk("bus_rules", 32'(viol), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
